// File: rtl/cpu_shift_stage_if.sv
// rtl/cpu_shift_stage_if.sv - operand request and shifted-operand handshake bundle
interface cpu_shift_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        is_imm;
    logic [7:0]  imm8;
    logic [3:0]  rot4;
    logic [31:0] rm_value;
    logic [1:0]  shift_type;
    logic        shift_by_reg;
    logic [4:0]  shamt5;
    logic [7:0]  rs_value;
    logic        c_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] b_out;
    logic        shift_carry;

    modport master (
        output in_valid, is_imm, imm8, rot4, rm_value, shift_type,
               shift_by_reg, shamt5, rs_value, c_flag, out_ready,
        input  in_ready, out_valid, b_out, shift_carry
    );

    modport slave (
        input  in_valid, is_imm, imm8, rot4, rm_value, shift_type,
               shift_by_reg, shamt5, rs_value, c_flag, out_ready,
        output in_ready, out_valid, b_out, shift_carry
    );
endinterface

// File: rtl/cpu_shift_stage.sv
// rtl/cpu_shift_stage.sv - operand-2 barrel shifter with a 2-entry registered skid buffer
module cpu_shift_stage #(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    cpu_shift_stage_if.slave  bus
);
    localparam logic [1:0] FULL   = 2'(DEPTH);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] d;
        d = {v, v} >> n;
        return d[31:0];
    endfunction

    logic [31:0] rm;
    logic [7:0]  rs;
    logic [4:0]  amt5;
    logic [32:0] lsl_t;
    logic [32:0] lsr_t;
    logic [32:0] asr_t;
    logic [31:0] ror_t;
    logic [31:0] sh_b;
    logic        sh_c;

    assign rm = bus.rm_value;
    assign rs = bus.rs_value;

    // The 33-bit temporaries carry the last bit shifted out alongside the result.
    always_comb begin
        amt5  = bus.shift_by_reg ? rs[4:0] : bus.shamt5;
        lsl_t = {1'b0, rm} << amt5;
        lsr_t = {rm, 1'b0} >> amt5;
        asr_t = $signed({rm, 1'b0}) >>> amt5;
        ror_t = ror32(rm, amt5);
        sh_b  = rm;
        sh_c  = bus.c_flag;
        if (bus.is_imm) begin
            sh_b = ror32({24'd0, bus.imm8}, {bus.rot4, 1'b0});
            sh_c = (bus.rot4 == 4'd0) ? bus.c_flag : sh_b[31];
        end else if (!bus.shift_by_reg) begin
            case (bus.shift_type)
                SH_LSL: if (bus.shamt5 != 5'd0) {sh_c, sh_b} = lsl_t;
                SH_LSR: if (bus.shamt5 == 5'd0) begin
                            sh_b = 32'd0;
                            sh_c = rm[31];
                        end else begin
                            sh_b = lsr_t[32:1];
                            sh_c = lsr_t[0];
                        end
                SH_ASR: if (bus.shamt5 == 5'd0) begin
                            sh_b = {32{rm[31]}};
                            sh_c = rm[31];
                        end else begin
                            sh_b = asr_t[32:1];
                            sh_c = asr_t[0];
                        end
                default: if (bus.shamt5 == 5'd0) begin
                            sh_b = {bus.c_flag, rm[31:1]};
                            sh_c = rm[0];
                        end else begin
                            sh_b = ror_t;
                            sh_c = ror_t[31];
                        end
            endcase
        end else if (rs != 8'd0) begin
            case (bus.shift_type)
                SH_LSL: if (rs < 8'd32) {sh_c, sh_b} = lsl_t;
                        else begin
                            sh_b = 32'd0;
                            sh_c = (rs == 8'd32) ? rm[0] : 1'b0;
                        end
                SH_LSR: if (rs < 8'd32) begin
                            sh_b = lsr_t[32:1];
                            sh_c = lsr_t[0];
                        end else begin
                            sh_b = 32'd0;
                            sh_c = (rs == 8'd32) ? rm[31] : 1'b0;
                        end
                SH_ASR: if (rs < 8'd32) begin
                            sh_b = asr_t[32:1];
                            sh_c = asr_t[0];
                        end else begin
                            sh_b = {32{rm[31]}};
                            sh_c = rm[31];
                        end
                default: if (rs[4:0] == 5'd0) begin
                            sh_b = rm;
                            sh_c = rm[31];
                        end else begin
                            sh_b = ror_t;
                            sh_c = ror_t[31];
                        end
            endcase
        end
    end

    logic [1:0]  count;
    logic [31:0] head_b;
    logic        head_c;
    logic [31:0] tail_b;
    logic        tail_c;
    logic        push;
    logic        pop;

    assign bus.in_ready    = (count != FULL);
    assign bus.out_valid   = (count != 2'd0);
    assign bus.b_out       = head_b;
    assign bus.shift_carry = head_c;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Head register doubles as the output, so an emptied buffer keeps showing its last entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            head_b <= 32'd0;
            head_c <= 1'b0;
            tail_b <= 32'd0;
            tail_c <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_b <= sh_b;
                        head_c <= sh_c;
                    end else begin
                        tail_b <= sh_b;
                        tail_c <= sh_c;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_b <= tail_b;
                        head_c <= tail_c;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    head_b <= sh_b;
                    head_c <= sh_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_shift_stage.sv
// tb/tb_cpu_shift_stage.sv - directed self-checking bench for cpu_shift_stage
module tb_cpu_shift_stage;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    cpu_shift_stage_if bus ();

    cpu_shift_stage #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic set_imm(input logic [7:0] v, input logic [3:0] r, input logic c);
        bus.is_imm = 1'b1;
        bus.imm8   = v;
        bus.rot4   = r;
        bus.c_flag = c;
    endtask

    task automatic set_shift(input logic [31:0] r, input logic [1:0] t, input logic by_reg,
                             input logic [4:0] sa, input logic [7:0] rsv, input logic c);
        bus.is_imm       = 1'b0;
        bus.rm_value     = r;
        bus.shift_type   = t;
        bus.shift_by_reg = by_reg;
        bus.shamt5       = sa;
        bus.rs_value     = rsv;
        bus.c_flag       = c;
    endtask

    task automatic run_op(input string tag, input logic [31:0] exp_b, input logic exp_c);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_b"}, bus.b_out, exp_b);
        check({tag, "_c"}, 32'(bus.shift_carry), 32'(exp_c));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_imm(8'h00, 4'h0, 1'b0);
        set_shift(32'h0, 2'b00, 1'b0, 5'd0, 8'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_b_out", bus.b_out, 32'd0);
        check("rst_carry", 32'(bus.shift_carry), 32'd0);

        set_imm(8'hFF, 4'd4, 1'b0);
        run_op("imm_rot8", 32'hFF000000, 1'b1);
        check("empty_valid", 32'(bus.out_valid), 32'd0);
        check("empty_hold_b", bus.b_out, 32'hFF000000);
        set_imm(8'h3C, 4'd0, 1'b1);
        run_op("imm_rot0", 32'h0000003C, 1'b1);

        set_shift(32'h80000001, 2'b10, 1'b0, 5'd0, 8'd0, 1'b0);
        run_op("asr_imm32", 32'hFFFFFFFF, 1'b1);
        set_shift(32'h80000001, 2'b11, 1'b0, 5'd0, 8'd0, 1'b1);
        run_op("rrx", 32'hC0000000, 1'b1);
        set_shift(32'hF0000001, 2'b00, 1'b0, 5'd4, 8'd0, 1'b0);
        run_op("lsl_imm4", 32'h00000010, 1'b1);
        set_shift(32'h80000000, 2'b01, 1'b0, 5'd0, 8'd0, 1'b0);
        run_op("lsr_imm32", 32'h00000000, 1'b1);
        set_shift(32'h000000AB, 2'b11, 1'b0, 5'd8, 8'd0, 1'b0);
        run_op("ror_imm8", 32'hAB000000, 1'b1);

        set_shift(32'h00000001, 2'b00, 1'b1, 5'd0, 8'd32, 1'b0);
        run_op("lsl_reg32", 32'h00000000, 1'b1);
        set_shift(32'h00000001, 2'b00, 1'b1, 5'd0, 8'd33, 1'b1);
        run_op("lsl_reg33", 32'h00000000, 1'b0);
        set_shift(32'h00000001, 2'b00, 1'b1, 5'd0, 8'd0, 1'b1);
        run_op("lsl_reg0", 32'h00000001, 1'b1);
        set_shift(32'h80000000, 2'b01, 1'b1, 5'd0, 8'd32, 1'b0);
        run_op("lsr_reg32", 32'h00000000, 1'b1);
        set_shift(32'h00000018, 2'b01, 1'b1, 5'd0, 8'd4, 1'b0);
        run_op("lsr_reg4", 32'h00000001, 1'b1);
        set_shift(32'h80000000, 2'b10, 1'b1, 5'd0, 8'd200, 1'b0);
        run_op("asr_reg200", 32'hFFFFFFFF, 1'b1);
        set_shift(32'h80000000, 2'b11, 1'b1, 5'd0, 8'd32, 1'b0);
        run_op("ror_reg32", 32'h80000000, 1'b1);

        bus.out_ready = 1'b0;
        set_imm(8'h11, 4'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        check("fill1_in_ready", 32'(bus.in_ready), 32'd1);
        set_imm(8'h22, 4'd0, 1'b0);
        tick();
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_head_a", bus.b_out, 32'h11);
        set_imm(8'h33, 4'd0, 1'b0);
        tick();
        check("full_ignored_ready", 32'(bus.in_ready), 32'd0);
        check("full_ignored_head", bus.b_out, 32'h11);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("drain_head_b", bus.b_out, 32'h22);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        check("drain_valid1", 32'(bus.out_valid), 32'd1);
        tick();
        check("drain_valid0", 32'(bus.out_valid), 32'd0);
        check("drain_hold_b", bus.b_out, 32'h22);

        bus.out_ready = 1'b0;
        set_imm(8'h44, 4'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        set_imm(8'h55, 4'd0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("pushpop_valid", 32'(bus.out_valid), 32'd1);
        check("pushpop_head", bus.b_out, 32'h55);
        check("pushpop_in_ready", 32'(bus.in_ready), 32'd1);
        set_imm(8'h66, 4'd0, 1'b0);
        bus.out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);

        set_imm(8'h77, 4'd0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        set_imm(8'h88, 4'd0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("pre_reset_full", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_valid", 32'(bus.out_valid), 32'd0);
        check("post_reset_b", bus.b_out, 32'd0);
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_reset_carry", 32'(bus.shift_carry), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
